// File: rtl/ifu_pc_gen_pkg.sv
// Shared fetch-unit types and constants.
// Used by the PC generator and the PC range checker.
package ifu_pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_FAULT     = 2'd1,
    ST_ERET_WAIT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SEL_SEQ   = 3'd0,
    SEL_BR    = 3'd1,
    SEL_JMP   = 3'd2,
    SEL_HOLD  = 3'd3,
    SEL_FAULT = 3'd4,
    SEL_ERET  = 3'd5,
    SEL_EXC   = 3'd6
  } sel_e;

  localparam logic [31:0] RESET_PC_C   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_C = 32'h0000_4180;

  localparam logic [31:0] TEXT_LO = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI = 32'h0000_4FFF;

  function automatic logic pc_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= TEXT_LO) && (a <= TEXT_HI);
  endfunction

endpackage

// File: rtl/ifu_pc_gen_pc_next_mux.sv
// Next-PC priority select for the fetch unit.
// Reports which source won so the FSM can follow it.
module pc_next_mux
  import ifu_pc_gen_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_C
) (
  input  state_e      i_state,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc_plus4,
  input  logic        i_exc_req,
  input  logic        i_eret,
  input  logic [31:0] i_epc,
  input  logic        i_pc_bad,
  input  logic        i_stall,
  input  logic        i_jmp,
  input  logic [31:0] i_jmp_target,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  output sel_e        o_sel,
  output logic [31:0] o_npc
);

  sel_e w_sel;

  // Pick the winning source; FAULT and ERET_WAIT only yield to exc_req.
  always_comb begin
    w_sel = SEL_SEQ;
    if (i_exc_req)                     w_sel = SEL_EXC;
    else if (i_state == ST_FAULT)      w_sel = SEL_SEQ;
    else if (i_state == ST_ERET_WAIT)  w_sel = SEL_HOLD;
    else if (i_eret)                   w_sel = SEL_ERET;
    else if (i_pc_bad)                 w_sel = SEL_FAULT;
    else if (i_stall)                  w_sel = SEL_HOLD;
    else if (i_jmp)                    w_sel = SEL_JMP;
    else if (i_br_taken)               w_sel = SEL_BR;
    else                               w_sel = SEL_SEQ;
  end

  // Map the winning source to an address.
  always_comb begin
    o_npc = i_pc_plus4;
    unique case (w_sel)
      SEL_EXC:   o_npc = HANDLER_PC;
      SEL_FAULT: o_npc = HANDLER_PC;
      SEL_ERET:  o_npc = i_epc;
      SEL_HOLD:  o_npc = i_pc;
      SEL_JMP:   o_npc = i_jmp_target;
      SEL_BR:    o_npc = i_br_target;
      default:   o_npc = i_pc_plus4;
    endcase
  end

  assign o_sel = w_sel;

endmodule

// File: rtl/ifu_pc_gen.sv
// Fetch PC generator: PC register, fault/eret FSM,
// fault address capture and valid-fetch counter.
module ifu_pc_gen
  import ifu_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_C,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        pc_bad,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        if_valid,
  output logic        exc_adel,
  output logic [31:0] bad_vaddr,
  output logic [31:0] fetch_cnt
);

  state_e      r_state;
  logic [31:0] r_pc;
  logic        r_exc_adel;
  logic [31:0] r_bad_vaddr;
  logic [31:0] r_fetch_cnt;

  sel_e        w_sel;
  logic [31:0] w_npc;
  logic [31:0] w_pc_plus4;
  logic        w_valid;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_valid    = (r_state == ST_RUN) && !pc_bad;

  pc_next_mux #(
    .HANDLER_PC(HANDLER_PC)
  ) u_mux (
    .i_state      (r_state),
    .i_pc         (r_pc),
    .i_pc_plus4   (w_pc_plus4),
    .i_exc_req    (exc_req),
    .i_eret       (eret),
    .i_epc        (epc),
    .i_pc_bad     (pc_bad),
    .i_stall      (stall),
    .i_jmp        (jmp),
    .i_jmp_target (jmp_target),
    .i_br_taken   (br_taken),
    .i_br_target  (br_target),
    .o_sel        (w_sel),
    .o_npc        (w_npc)
  );

  // PC, FSM, fault capture and fetch counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_state     <= ST_RUN;
      r_exc_adel  <= 1'b0;
      r_bad_vaddr <= 32'd0;
      r_fetch_cnt <= 32'd0;
    end else begin
      r_pc       <= w_npc;
      r_exc_adel <= (w_sel == SEL_FAULT);
      if (w_sel == SEL_FAULT)
        r_bad_vaddr <= r_pc;
      if (w_valid && !stall)
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      unique case (r_state)
        ST_RUN: begin
          if (w_sel == SEL_ERET)
            r_state <= ST_ERET_WAIT;
          else if (w_sel == SEL_FAULT)
            r_state <= ST_FAULT;
          else
            r_state <= ST_RUN;
        end
        ST_FAULT:
          r_state <= ST_RUN;
        ST_ERET_WAIT: begin
          if (exc_req || !stall)
            r_state <= ST_RUN;
          else
            r_state <= ST_ERET_WAIT;
        end
        default:
          r_state <= ST_RUN;
      endcase
    end
  end

  assign pc        = r_pc;
  assign pc_plus4  = w_pc_plus4;
  assign if_valid  = w_valid;
  assign exc_adel  = r_exc_adel;
  assign bad_vaddr = r_bad_vaddr;
  assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_ifu_pc_gen.sv
// Bench for ifu_pc_gen: directed scenarios plus a
// randomized run against a behavioural fetch model.
module tb_ifu_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic        pc_bad;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        if_valid;
  logic        exc_adel;
  logic [31:0] bad_vaddr;
  logic [31:0] fetch_cnt;

  int total = 0;
  int bad   = 0;

  ifu_pc_gen dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .exc_req    (exc_req),
    .eret       (eret),
    .epc        (epc),
    .pc_bad     (pc_bad),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .if_valid   (if_valid),
    .exc_adel   (exc_adel),
    .bad_vaddr  (bad_vaddr),
    .fetch_cnt  (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset      = 1'b0;
    stall      = 1'b0;
    br_taken   = 1'b0;
    br_target  = 32'd0;
    jmp        = 1'b0;
    jmp_target = 32'd0;
    exc_req    = 1'b0;
    eret       = 1'b0;
    epc        = 32'd0;
    pc_bad     = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  function automatic logic chk_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < 32'h3000) || (a > 32'h4FFF);
  endfunction

  function automatic logic [31:0] rnd_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)
      return 32'h3000 + (32'($urandom_range(0, 32'h1FFC)) & ~32'h3);
    else if (r < 9)
      return 32'h3000 + 32'($urandom_range(0, 32'h1FFF));
    else
      return 32'($urandom());
  endfunction

  task automatic test_reset();
    idle();
    reset = 1'b1;
    jmp = 1'b1;
    jmp_target = 32'h3400;
    exc_req = 1'b1;
    pc_bad = 1'b1;
    stall = 1'b1;
    cyc();
    total++;
    if (pc !== 32'h3000) begin
      bad++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h3000);
    end
    total++;
    if (exc_adel !== 1'b0) begin
      bad++; $display("FAIL rst_adel got=%b exp=0", exc_adel);
    end
    total++;
    if (bad_vaddr !== 32'h0) begin
      bad++; $display("FAIL rst_badv got=%h exp=0", bad_vaddr);
    end
    total++;
    if (fetch_cnt !== 32'h0) begin
      bad++; $display("FAIL rst_cnt got=%h exp=0", fetch_cnt);
    end
    idle();
    #1;
    total++;
    if (if_valid !== 1'b1) begin
      bad++; $display("FAIL rst_first_valid got=%b exp=1", if_valid);
    end
    total++;
    if (pc_plus4 !== 32'h3004) begin
      bad++; $display("FAIL rst_pc4 got=%h exp=%h", pc_plus4, 32'h3004);
    end
  endtask

  task automatic test_free_run_jmp_br();
    do_reset();
    cyc();
    total++;
    if (pc !== 32'h3004) begin
      bad++; $display("FAIL run_pc1 got=%h exp=%h", pc, 32'h3004);
    end
    cyc();
    total++;
    if (pc !== 32'h3008) begin
      bad++; $display("FAIL run_pc2 got=%h exp=%h", pc, 32'h3008);
    end
    total++;
    if (fetch_cnt !== 32'd2) begin
      bad++; $display("FAIL run_cnt got=%0d exp=2", fetch_cnt);
    end
    br_taken = 1'b1;
    br_target = 32'h3100;
    jmp = 1'b1;
    jmp_target = 32'h3200;
    cyc();
    idle();
    total++;
    if (pc !== 32'h3200) begin
      bad++; $display("FAIL jmp_wins got=%h exp=%h", pc, 32'h3200);
    end
    br_taken = 1'b1;
    br_target = 32'h3300;
    cyc();
    idle();
    total++;
    if (pc !== 32'h3300) begin
      bad++; $display("FAIL br_only got=%h exp=%h", pc, 32'h3300);
    end
  endtask

  task automatic test_stall();
    do_reset();
    cyc();
    cyc();
    cyc();
    stall = 1'b1;
    jmp = 1'b1;
    jmp_target = 32'h3500;
    cyc();
    cyc();
    total++;
    if (pc !== 32'h300C) begin
      bad++; $display("FAIL stall_pc got=%h exp=%h", pc, 32'h300C);
    end
    total++;
    if (fetch_cnt !== 32'd3) begin
      bad++; $display("FAIL stall_cnt got=%0d exp=3", fetch_cnt);
    end
    idle();
    cyc();
    total++;
    if (pc !== 32'h3010) begin
      bad++; $display("FAIL stall_rel got=%h exp=%h", pc, 32'h3010);
    end
    total++;
    if (fetch_cnt !== 32'd4) begin
      bad++; $display("FAIL stall_rel_cnt got=%0d exp=4", fetch_cnt);
    end
  endtask

  task automatic test_fault();
    do_reset();
    jmp = 1'b1;
    jmp_target = 32'h3002;
    cyc();
    idle();
    total++;
    if (pc !== 32'h3002) begin
      bad++; $display("FAIL flt_unchk got=%h exp=%h", pc, 32'h3002);
    end
    stall = 1'b1;
    pc_bad = 1'b1;
    #1;
    total++;
    if (if_valid !== 1'b0) begin
      bad++; $display("FAIL flt_valid got=%b exp=0", if_valid);
    end
    cyc();
    pc_bad = 1'b0;
    jmp = 1'b1;
    jmp_target = 32'h3600;
    eret = 1'b1;
    epc = 32'h3700;
    #1;
    total++;
    if (pc !== 32'h4180) begin
      bad++; $display("FAIL flt_pc got=%h exp=%h", pc, 32'h4180);
    end
    total++;
    if (exc_adel !== 1'b1) begin
      bad++; $display("FAIL flt_adel got=%b exp=1", exc_adel);
    end
    total++;
    if (bad_vaddr !== 32'h3002) begin
      bad++; $display("FAIL flt_badv got=%h exp=%h", bad_vaddr, 32'h3002);
    end
    total++;
    if (if_valid !== 1'b0) begin
      bad++; $display("FAIL flt_state_valid got=%b exp=0", if_valid);
    end
    cyc();
    idle();
    #1;
    total++;
    if (pc !== 32'h4184) begin
      bad++; $display("FAIL flt_after got=%h exp=%h", pc, 32'h4184);
    end
    total++;
    if (exc_adel !== 1'b0) begin
      bad++; $display("FAIL flt_pulse got=%b exp=0", exc_adel);
    end
    total++;
    if (if_valid !== 1'b1) begin
      bad++; $display("FAIL flt_rec_valid got=%b exp=1", if_valid);
    end
    total++;
    if (fetch_cnt !== 32'd1) begin
      bad++; $display("FAIL flt_cnt got=%0d exp=1", fetch_cnt);
    end
  endtask

  task automatic test_exc_eret();
    do_reset();
    cyc();
    exc_req = 1'b1;
    eret = 1'b1;
    epc = 32'h3010;
    cyc();
    idle();
    #1;
    total++;
    if (pc !== 32'h4180) begin
      bad++; $display("FAIL exc_wins got=%h exp=%h", pc, 32'h4180);
    end
    total++;
    if (if_valid !== 1'b1) begin
      bad++; $display("FAIL exc_no_wait got=%b exp=1", if_valid);
    end
    cyc();
    eret = 1'b1;
    epc = 32'h3010;
    cyc();
    idle();
    #1;
    total++;
    if (pc !== 32'h3010) begin
      bad++; $display("FAIL eret_pc got=%h exp=%h", pc, 32'h3010);
    end
    total++;
    if (if_valid !== 1'b0) begin
      bad++; $display("FAIL eret_wait got=%b exp=0", if_valid);
    end
    cyc();
    total++;
    if (pc !== 32'h3010 || if_valid !== 1'b1) begin
      bad++; $display("FAIL eret_resume got=%h/%b exp=%h/1", pc, if_valid, 32'h3010);
    end
    cyc();
    total++;
    if (pc !== 32'h3014) begin
      bad++; $display("FAIL eret_next got=%h exp=%h", pc, 32'h3014);
    end
    eret = 1'b1;
    epc = 32'h3100;
    cyc();
    idle();
    stall = 1'b1;
    cyc();
    #1;
    total++;
    if (pc !== 32'h3100 || if_valid !== 1'b0) begin
      bad++; $display("FAIL eret_stall got=%h/%b exp=%h/0", pc, if_valid, 32'h3100);
    end
    stall = 1'b0;
    cyc();
    total++;
    if (pc !== 32'h3100 || if_valid !== 1'b1) begin
      bad++; $display("FAIL eret_stall_rel got=%h/%b exp=%h/1", pc, if_valid, 32'h3100);
    end
    exc_req = 1'b1;
    pc_bad = 1'b1;
    cyc();
    idle();
    total++;
    if (pc !== 32'h4180 || exc_adel !== 1'b0) begin
      bad++; $display("FAIL exc_over_bad got=%h/%b exp=%h/0", pc, exc_adel, 32'h4180);
    end
    total++;
    if (bad_vaddr !== 32'h0) begin
      bad++; $display("FAIL exc_over_badv got=%h exp=0", bad_vaddr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pc_bad = 1'b1;
    cyc();
    pc_bad = 1'b0;
    reset = 1'b1;
    jmp = 1'b1;
    jmp_target = 32'h3800;
    exc_req = 1'b1;
    cyc();
    idle();
    total++;
    if (pc !== 32'h3000 || exc_adel !== 1'b0) begin
      bad++; $display("FAIL rst_fault got=%h/%b exp=%h/0", pc, exc_adel, 32'h3000);
    end
    total++;
    if (bad_vaddr !== 32'h0) begin
      bad++; $display("FAIL rst_fault_badv got=%h exp=0", bad_vaddr);
    end
    eret = 1'b1;
    epc = 32'h3900;
    cyc();
    idle();
    reset = 1'b1;
    stall = 1'b1;
    cyc();
    idle();
    #1;
    total++;
    if (pc !== 32'h3000 || if_valid !== 1'b1) begin
      bad++; $display("FAIL rst_wait got=%h/%b exp=%h/1", pc, if_valid, 32'h3000);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    jmp = 1'b1;
    jmp_target = 32'hFFFF_FFFC;
    cyc();
    idle();
    #1;
    total++;
    if (pc_plus4 !== 32'h0) begin
      bad++; $display("FAIL wrap_pc4 got=%h exp=0", pc_plus4);
    end
    cyc();
    total++;
    if (pc !== 32'h0) begin
      bad++; $display("FAIL wrap_pc got=%h exp=0", pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] m_pc, m_cnt, m_badv;
    logic        m_adel, m_fault, m_wait, e_valid;
    do_reset();
    m_pc = 32'h3000;
    m_cnt = 0;
    m_badv = 0;
    m_adel = 0;
    m_fault = 0;
    m_wait = 0;
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 60) == 0);
      stall      = ($urandom_range(0, 4) == 0);
      jmp        = ($urandom_range(0, 5) == 0);
      br_taken   = ($urandom_range(0, 4) == 0);
      exc_req    = ($urandom_range(0, 25) == 0);
      eret       = ($urandom_range(0, 15) == 0);
      jmp_target = rnd_addr();
      br_target  = rnd_addr();
      epc        = rnd_addr();
      pc_bad     = chk_bad(m_pc) || ($urandom_range(0, 40) == 0);
      #1;
      e_valid = !m_fault && !m_wait && !pc_bad;
      total++;
      if (if_valid !== e_valid) begin
        bad++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, if_valid, e_valid);
      end
      if (reset) begin
        m_pc = 32'h3000; m_cnt = 0; m_badv = 0;
        m_adel = 0; m_fault = 0; m_wait = 0;
      end else begin
        if (e_valid && !stall) m_cnt = m_cnt + 1;
        m_adel = 0;
        if (exc_req) begin
          m_pc = 32'h4180; m_fault = 0; m_wait = 0;
        end else if (m_fault) begin
          m_pc = m_pc + 4; m_fault = 0;
        end else if (m_wait) begin
          if (!stall) m_wait = 0;
        end else if (eret) begin
          m_pc = epc; m_wait = 1;
        end else if (pc_bad) begin
          m_badv = m_pc; m_pc = 32'h4180;
          m_adel = 1; m_fault = 1;
        end else if (!stall) begin
          if (jmp) m_pc = jmp_target;
          else if (br_taken) m_pc = br_target;
          else m_pc = m_pc + 4;
        end
      end
      cyc();
      total++;
      if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4) begin
        bad++; $display("FAIL rnd_pc i=%0d got=%h/%h exp=%h", i, pc, pc_plus4, m_pc);
      end
      total++;
      if (exc_adel !== m_adel || bad_vaddr !== m_badv) begin
        bad++; $display("FAIL rnd_adel i=%0d got=%b/%h exp=%b/%h", i, exc_adel, bad_vaddr, m_adel, m_badv);
      end
      total++;
      if (fetch_cnt !== m_cnt) begin
        bad++; $display("FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, fetch_cnt, m_cnt);
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_free_run_jmp_br();
    test_stall();
    test_fault();
    test_exc_eret();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu_pc_gen.md
IFU_PC_GEN -- requirements
Module: ifu_pc_gen

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with ports declared in this order:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
REQ-002 Parameters (name, default, meaning):
- RESET_PC, 32'h0000_3000, boot address.
- HANDLER_PC, 32'h0000_4180, exception entry address.
REQ-003 Remaining ports (name, direction, width, meaning):
- stall  input  1  hold PC (hazard unit).
- br_taken  input  1  branch redirect request.
- br_target  input  32  branch target.
- jmp  input  1  jump or jr redirect request.
- jmp_target  input  32  jump or jr target.
- exc_req  input  1  downstream exception commit.
- eret  input  1  exception return.
- epc  input  32  return address.
- pc_bad  input  1  from the downstream PC address checker: current pc is out of range or misaligned.
- pc  output  32  current fetch address.
- pc_plus4  output  32  pc+4.
- if_valid  output  1  current fetch is usable.
- exc_adel  output  1  one-cycle fetch-fault pulse.
- bad_vaddr  output  32  last faulting fetch address.
- fetch_cnt  output  32  count of valid fetches.

Function
REQ-004 pc SHALL be a register; pc_plus4 SHALL be combinational pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-005 The FSM SHALL have states RUN, FAULT and ERET_WAIT; the reset state is RUN.
REQ-006 In RUN, next-pc priority SHALL be: exc_req -> HANDLER_PC; eret -> epc; pc_bad -> HANDLER_PC; stall -> pc; jmp -> jmp_target; br_taken -> br_target; otherwise pc_plus4.
REQ-007 In RUN with pc_bad=1 and exc_req=0 and eret=0:
- bad_vaddr SHALL load pc;
- exc_adel SHALL assert for exactly the next cycle;
- the state SHALL go to FAULT.
- This holds regardless of stall: a fault overrides stall.
REQ-008 FAULT SHALL last one cycle:
- pc = HANDLER_PC, exc_adel=1, if_valid=0;
- the next state is RUN;
- all redirect inputs are ignored, except reset and exc_req; exc_req reloads HANDLER_PC.
REQ-009 eret accepted in RUN SHALL load epc and enter ERET_WAIT for one cycle:
- if_valid=0 in that cycle;
- stall is honoured (the state holds while stall=1);
- the state then returns to RUN.
REQ-010 if_valid SHALL be 1 only in RUN with pc_bad=0.
REQ-011 fetch_cnt SHALL increment by 1 on each cycle where if_valid=1 and stall=0, and SHALL wrap from 0xFFFF_FFFF to 0.
REQ-012 Simultaneous branch and jump: jump wins.
REQ-013 Simultaneous exc_req and eret: exc_req wins.
REQ-014 Simultaneous exc_req and pc_bad: exc_req wins; no exc_adel is raised and bad_vaddr is unchanged.
REQ-015 Redirect targets SHALL be taken unchecked; misalignment is flagged one cycle later via pc_bad.
REQ-016 All outputs SHALL be register-driven except pc_plus4 and if_valid.

Reset
REQ-017 On reset, the following SHALL hold on the next edge:
- pc=RESET_PC;
- state=RUN;
- exc_adel=0;
- bad_vaddr=0;
- fetch_cnt=0.
REQ-018 Reset SHALL override every input, including mid-FAULT and mid-ERET_WAIT.
REQ-019 The first valid fetch SHALL occur in the first cycle after reset deasserts.

Structure
REQ-020 The shared package SHALL hold:
- the FSM state encoding (RUN, FAULT, ERET_WAIT);
- RESET_PC and HANDLER_PC constants;
- the text range bounds 0x3000..0x4FFF, shared with the checker.
REQ-021 There SHALL be one sub-module, pc_next_mux: a combinational next-PC priority select. The FSM, pc register and counters SHALL live in the top module.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then 3 free-running cycles -> pc=0x3000, 0x3004, 0x3008; fetch_cnt=2 after cycle 3.
- At pc=0x3008, br_taken=1 with br_target=0x3100, and jmp=1 with jmp_target=0x3200, in the same cycle -> next pc=0x3200.
- stall=1 for 2 cycles at pc=0x300C -> pc holds at 0x300C and fetch_cnt is frozen; when released -> 0x3010.
- jmp_target=0x3002, then pc_bad=1 while stall=1 -> bad_vaddr=0x3002, one-cycle exc_adel, pc=0x4180, then 0x4184.
- exc_req=1 with eret=1 and epc=0x3010 -> pc=0x4180 and no ERET_WAIT; a later eret alone -> pc=0x3010 with 1 invalid cycle.
- Reset asserted during FAULT -> pc=0x3000 and exc_adel=0 on the next edge.
